// File: rtl/regfile_mp.sv
// Multi-port integer register file with hardwired x0, optional write-to-read bypass and a
// per-register pending-write scoreboard fed by decode reservations.
module regfile_mp #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned NUM_REGS  = 32,
    parameter int unsigned NUM_READ  = 2,
    parameter int unsigned NUM_WRITE = 1,
    parameter bit          BYPASS    = 1'b1,
    localparam int unsigned AW       = $clog2(NUM_REGS)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NUM_READ-1:0]       rd_en_i,
    input  logic [NUM_READ*AW-1:0]    rd_addr_i,
    output logic [NUM_READ*XLEN-1:0]  rd_data_o,
    output logic [NUM_READ-1:0]       rd_busy_o,
    input  logic [NUM_WRITE-1:0]      wr_en_i,
    input  logic [NUM_WRITE*AW-1:0]   wr_addr_i,
    input  logic [NUM_WRITE*XLEN-1:0] wr_data_i,
    input  logic                      rsv_en_i,
    input  logic [AW-1:0]             rsv_addr_i
);

    logic [XLEN-1:0]          regs_q [NUM_REGS];
    logic [XLEN-1:0]          regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]      pend_q, pend_wr, pend_d;
    logic [NUM_READ*XLEN-1:0] rd_data_q, rd_data_d;
    logic [NUM_READ-1:0]      rd_busy_q, rd_busy_d;

    // x0 and out-of-range addresses (non-power-of-two depths) never touch state.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (a != '0) && (32'(a) < NUM_REGS);
    endfunction

    always_comb begin
        regs_d  = regs_q;
        pend_wr = pend_q;
        // Ascending port order lets the highest-index port win a same-address conflict.
        for (int w = 0; w < int'(NUM_WRITE); w++) begin
            if (wr_en_i[w] && addr_ok(wr_addr_i[w*AW +: AW])) begin
                regs_d[wr_addr_i[w*AW +: AW]]  = wr_data_i[w*XLEN +: XLEN];
                pend_wr[wr_addr_i[w*AW +: AW]] = 1'b0;
            end
        end
        pend_d = pend_wr;
        if (rsv_en_i && addr_ok(rsv_addr_i)) begin
            pend_d[rsv_addr_i] = 1'b1;
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        rd_busy_d = rd_busy_q;
        for (int p = 0; p < int'(NUM_READ); p++) begin
            if (rd_en_i[p]) begin
                if (!addr_ok(rd_addr_i[p*AW +: AW])) begin
                    rd_data_d[p*XLEN +: XLEN] = '0;
                    rd_busy_d[p]              = 1'b0;
                end else if (BYPASS) begin
                    // Same-cycle reservations only become visible on the next read.
                    rd_data_d[p*XLEN +: XLEN] = regs_d[rd_addr_i[p*AW +: AW]];
                    rd_busy_d[p]              = pend_wr[rd_addr_i[p*AW +: AW]];
                end else begin
                    rd_data_d[p*XLEN +: XLEN] = regs_q[rd_addr_i[p*AW +: AW]];
                    rd_busy_d[p]              = pend_q[rd_addr_i[p*AW +: AW]];
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= '0;
            end
            pend_q    <= '0;
            rd_data_q <= '0;
            rd_busy_q <= '0;
        end else begin
            regs_q    <= regs_d;
            pend_q    <= pend_d;
            rd_data_q <= rd_data_d;
            rd_busy_q <= rd_busy_d;
        end
    end

    assign rd_data_o = rd_data_q;
    assign rd_busy_o = rd_busy_q;

    x0_invariant: assert property (@(posedge clk_i) disable iff (rst_i)
        (regs_q[0] == '0) && !pend_q[0])
        else $fatal(1, "x0 invariant violated");

endmodule
